ram_sp_clear: RTL and testbench
===============================

Name: ram_sp_clear

Overview:
- Parametrised single-port synchronous RAM: next generation of the team's 16x4 RAM.
- Adds configurable width and depth, a registered read with a valid strobe, and defined read/write collision behaviour.
- Adds a hardware clear engine that sweeps every word to zero after reset and on request, so unwritten locations always read 0.
- Used as general scratch storage behind simple controllers in the design.

Parameters:
- DATA_WIDTH, 8, word width in bits (>=1).
- ADDR_WIDTH, 4, address width in bits (>=1). DEPTH = 2**ADDR_WIDTH is derived internally and is not overridable.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear_start  input  1  request a full memory clear sweep.
- busy  output  1  high while the clear sweep runs; user accesses are refused.
- write_enable  input  1  write data_in to mem[address].
- read_enable  input  1  read mem[address].
- address  input  ADDR_WIDTH  word address.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  registered read data.
- read_valid  output  1  one-cycle strobe: data_out updated this cycle.
- access_dropped  output  1  one-cycle strobe: a read or write was refused because busy was high.

Behaviour:
- Reset (asynchronous assert):
  - state=CLEAR, clear_ptr=0, busy=1, data_out=0, read_valid=0, access_dropped=0.
  - The memory array itself is not reset; the sweep zeroes it.
- FSM states are IDLE and CLEAR.
- CLEAR:
  - Each rising edge writes mem[clear_ptr]=0 and increments clear_ptr.
  - The edge that writes DEPTH-1 moves the FSM to IDLE and drops busy.
  - busy is therefore high for exactly DEPTH rising edges after reset release or after entry.
- IDLE -> CLEAR:
  - Triggered by clear_start=1 at an edge: clear_ptr=0, busy=1 from that edge.
  - Any user access presented in that same cycle is still served, because busy was low when sampled.
  - The sweep starts at the next edge.
- clear_start while already in CLEAR is ignored; the sweep does not restart.
- reset asserted mid-sweep: the sweep restarts from address 0 after release.
- User access is gated by busy as sampled at the edge.
- Access refused while busy (read_enable or write_enable high):
  - No memory change.
  - data_out holds; read_valid=0.
  - access_dropped=1 for one cycle.
- Write (IDLE): mem[address]=data_in at the edge.
- Read (IDLE), latency 1:
  - At the edge, data_out <= mem[address] and read_valid=1 for that cycle only.
  - data_out holds its value until the next accepted read.
- Simultaneous read and write (same address by construction, single port): write-first. mem[address]=data_in, data_out=data_in, read_valid=1.
- Address wrap: address is exactly ADDR_WIDTH bits, so there is no out-of-range condition. clear_ptr wraps internally only as the terminal count.
- read_valid and access_dropped are never high in the same cycle.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=4, DEPTH=16):
- Release reset, hold no access -> busy=1 for exactly 16 edges then 0. After that, read of addresses 0..15 all return 0x00, each with a read_valid pulse.
- Idle: write 0x09 @3, write 0x0C @7, read 3, read 7, read 5 -> data_out 0x09, 0x0C, 0x00, each one cycle after its read, read_valid=1 on each.
- Idle: write_enable=1, read_enable=1, address=0xA, data_in=0x5A -> next edge data_out=0x5A, read_valid=1. A later read of 0xA returns 0x5A.
- Write 0x33 @2, pulse clear_start, then write 0x77 @4 at sweep cycle 5 -> access_dropped=1 for one cycle, busy=1 for 16 edges. After the sweep, reads of 2 and 4 return 0x00.
- Reset asserted at sweep cycle 8, released 2 cycles later -> data_out=0 and read_valid=0 immediately, busy=1 for a fresh 16 edges. No user write lands during this window.
- clear_start held high across a whole sweep -> the sweep runs 16 edges once. busy then drops for at least one cycle before the held request starts a new sweep.

Source files
------------

// File: rtl/ram_sp_clear.sv
// Single-port RAM with write-first registered read and a hardware zero-fill sweep.
// Latency: read data and read_valid appear 1 cycle after an accepted read; a clear sweep takes 2**ADDR_WIDTH cycles.
// Backpressure: while busy, user reads/writes are refused (not stalled) and flagged with a one-cycle access_dropped.
module ram_sp_clear #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_start,
    output logic                  busy,
    input  logic                  write_enable,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  read_valid,
    output logic                  access_dropped
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clear_ptr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Single physical write port, shared between the sweep and user writes.
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    user_req;

    assign user_req = read_enable | write_enable;

    // Steer the write port: the sweep owns it whenever busy, otherwise user writes use it.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = address;
        mem_wdata = data_in;
        if (busy) begin
            mem_we    = 1'b1;
            mem_addr  = clear_ptr;
            mem_wdata = '0;
        end else if (write_enable) begin
            mem_we    = 1'b1;
        end
    end

    // Storage array: deliberately not reset, the sweep zeroes it after reset release.
    // Writes are suppressed while reset is held so nothing lands in that window.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Clear FSM: busy mirrors the CLEAR state as a registered output.
    // A request seen while already sweeping is ignored; the sweep never restarts mid-way.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= CLEAR;
            clear_ptr <= '0;
            busy      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state     <= CLEAR;
                        clear_ptr <= '0;
                        busy      <= 1'b1;
                    end
                end
                CLEAR: begin
                    clear_ptr <= clear_ptr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    if (clear_ptr == {ADDR_WIDTH{1'b1}}) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Read path: gated by busy as sampled at the edge; write-first on a simultaneous read+write.
    // read_valid and access_dropped are mutually exclusive since they depend on opposite busy values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out       <= '0;
            read_valid     <= 1'b0;
            access_dropped <= 1'b0;
        end else begin
            read_valid     <= 1'b0;
            access_dropped <= 1'b0;
            if (busy) begin
                access_dropped <= user_req;
            end else if (read_enable) begin
                read_valid <= 1'b1;
                data_out   <= write_enable ? data_in : mem[address];
            end
        end
    end

endmodule

// File: tb/tb_ram_sp_clear.sv
// Directed bench for ram_sp_clear with a queue-based read scoreboard.
// Stimulus drives on the falling edge; the monitor samples 1ns after each rising edge.
// Expected read data and arrival cycle are queued at issue time and popped on read_valid.
module tb_ram_sp_clear;

    logic       clk;
    logic       reset;
    logic       clear_start;
    logic       busy;
    logic       write_enable;
    logic       read_enable;
    logic [3:0] address;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       read_valid;
    logic       access_dropped;

    ram_sp_clear #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .clear_start    (clear_start),
        .busy           (busy),
        .write_enable   (write_enable),
        .read_enable    (read_enable),
        .address        (address),
        .data_in        (data_in),
        .data_out       (data_out),
        .read_valid     (read_valid),
        .access_dropped (access_dropped)
    );

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   drop_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every read_valid and counts refused accesses.
    always @(posedge clk) begin
        #1;
        if (read_valid && access_dropped) check("rv_and_drop_together", 1, 0);
        if (access_dropped) drop_cnt++;
        if (read_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_read_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rd_data", data_out, e.data);
                check("rd_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic idle_inputs();
        write_enable = 1'b0;
        read_enable  = 1'b0;
        clear_start  = 1'b0;
        address      = '0;
        data_in      = '0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        write_enable = 1'b1;
        address      = a;
        data_in      = d;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic do_read(input logic [3:0] a, input logic [7:0] exp);
        exp_t e;
        read_enable = 1'b1;
        address     = a;
        e.data      = exp;
        e.cyc       = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic do_read_write(input logic [3:0] a, input logic [7:0] d);
        exp_t e;
        read_enable  = 1'b1;
        write_enable = 1'b1;
        address      = a;
        data_in      = d;
        e.data       = d;
        e.cyc        = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        idle_inputs();
    endtask

    // Counts rising edges during which busy stays high, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int drops_before;
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("reset_busy", busy, 1);
        check("reset_data_out", data_out, 0);
        check("reset_read_valid", read_valid, 0);
        check("reset_access_dropped", access_dropped, 0);

        // Post-reset sweep length, then every word reads zero
        reset = 1'b0;
        count_busy(n);
        check("reset_sweep_edges", n, 16);
        for (int a = 0; a < 16; a++) do_read(4'(a), 8'h00);

        // Basic writes and reads, including an unwritten location
        do_write(4'd3, 8'h09);
        do_write(4'd7, 8'h0C);
        do_read(4'd3, 8'h09);
        do_read(4'd7, 8'h0C);
        do_read(4'd5, 8'h00);

        // Simultaneous read+write is write-first, and the write persists
        do_read_write(4'hA, 8'h5A);
        @(negedge clk);
        do_read(4'hA, 8'h5A);

        // Clear request with an access refused mid-sweep
        do_write(4'd2, 8'h33);
        do_read(4'd2, 8'h33);
        drops_before = drop_cnt;
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            if (n == 5) begin
                write_enable = 1'b1;
                address      = 4'd4;
                data_in      = 8'h77;
            end else begin
                write_enable = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        idle_inputs();
        check("clear_sweep_edges", n, 16);
        check("dropped_count", drop_cnt - drops_before, 1);
        do_read(4'd2, 8'h00);
        do_read(4'd4, 8'h00);

        // Reset mid-sweep restarts the sweep; held data_out cleared immediately
        do_write(4'd1, 8'h44);
        do_read(4'd1, 8'h44);
        drops_before = drop_cnt;
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        repeat (8) @(negedge clk);
        reset        = 1'b1;
        write_enable = 1'b1;
        address      = 4'd1;
        data_in      = 8'hEE;
        #1;
        check("midreset_data_out", data_out, 0);
        check("midreset_read_valid", read_valid, 0);
        check("midreset_busy", busy, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        count_busy(n);
        check("midreset_sweep_edges", n, 16);
        check("midreset_no_drops", drop_cnt - drops_before, 0);
        do_read(4'd1, 8'h00);

        // Held clear request: one full sweep, a busy-low gap, then a new sweep
        clear_start = 1'b1;
        @(negedge clk);
        count_busy(n);
        check("held_first_sweep_edges", n, 16);
        check("held_gap_busy_low", busy, 0);
        @(negedge clk);
        check("held_second_sweep_busy", busy, 1);
        clear_start = 1'b0;
        count_busy(n);
        check("held_second_sweep_edges", n, 16);
        do_read(4'd0, 8'h00);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
